// File: rtl/bank_htu_req_queue.sv
// bank_htu_req_queue: in-order request FIFO feeding the tag pipeline, with an
// in-order in-flight tracker that holds back a head whose line is still outstanding.
module bank_htu_req_queue #(
  parameter int DEPTH = 4,
  parameter int INFL  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     xbar_htu_valid_i,
  output logic                     xbar_htu_ready_o,
  input  logic [1:0]               xbar_htu_ch_id_i,
  input  logic [1:0]               xbar_htu_opcode_i,
  input  logic [31:4]              xbar_htu_addr_i,
  input  logic [7:0]               xbar_htu_wbuffer_id_i,
  output logic                     htu_pipe_valid_o,
  input  logic                     htu_pipe_ready_i,
  output logic [1:0]               htu_pipe_ch_id_o,
  output logic [1:0]               htu_pipe_opcode_o,
  output logic [31:4]              htu_pipe_addr_o,
  output logic [7:0]               htu_pipe_wbuffer_id_o,
  input  logic                     htu_pipe_done_i,
  output logic [$clog2(DEPTH):0]   queue_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(INFL);
  logic [39:0]     mem_q [DEPTH];
  logic [39:0]     head;
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic [INFL-1:0] tv_q, tv_d;
  logic [31:4]     ta_q [INFL];
  logic [TW-1:0]   tw_q, tw_d, tr_q, tr_d;
  logic            full, empty, hit, push, pop, done;
  always_comb begin
    head = mem_q[rd_q[AW-1:0]];
    full = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    empty = wr_q == rd_q;
    hit = 1'b0;
    for (int i = 0; i < INFL; i++) hit = hit | (tv_q[i] && ta_q[i] == head[35:8]);
    xbar_htu_ready_o = !full;
    htu_pipe_valid_o = !empty && !hit && !(&tv_q);
    {htu_pipe_ch_id_o, htu_pipe_opcode_o, htu_pipe_addr_o, htu_pipe_wbuffer_id_o} = head;
    push = xbar_htu_valid_i && !full;
    pop = htu_pipe_valid_o && htu_pipe_ready_i;
    done = htu_pipe_done_i && (|tv_q);
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
    tw_d = tw_q + TW'(pop);
    tr_d = tr_q + TW'(done);
    tv_d = tv_q;
    if (done) tv_d[tr_q] = 1'b0;
    if (pop) tv_d[tw_q] = 1'b1;
    queue_cnt_o = wr_q - rd_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      tv_q <= '0;
      tw_q <= '0;
      tr_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      tv_q <= tv_d;
      tw_q <= tw_d;
      tr_q <= tr_d;
    end
  end
  // Payload and tracker addresses carry no reset; valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {xbar_htu_ch_id_i, xbar_htu_opcode_i, xbar_htu_addr_i, xbar_htu_wbuffer_id_i};
    if (pop) ta_q[tw_q] <= head[35:8];
  end
endmodule

// File: tb/tb_bank_htu_req_queue.sv
// tb_bank_htu_req_queue: directed scenarios with a payload scoreboard checked at each issue.
module tb_bank_htu_req_queue;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        xbar_htu_valid_i = 1'b0;
  logic        xbar_htu_ready_o;
  logic [1:0]  xbar_htu_ch_id_i = '0;
  logic [1:0]  xbar_htu_opcode_i = '0;
  logic [31:4] xbar_htu_addr_i = '0;
  logic [7:0]  xbar_htu_wbuffer_id_i = '0;
  logic        htu_pipe_valid_o;
  logic        htu_pipe_ready_i = 1'b0;
  logic [1:0]  htu_pipe_ch_id_o;
  logic [1:0]  htu_pipe_opcode_o;
  logic [31:4] htu_pipe_addr_o;
  logic [7:0]  htu_pipe_wbuffer_id_o;
  logic        htu_pipe_done_i = 1'b0;
  logic [2:0]  queue_cnt_o;
  logic [39:0] sb [$];
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  bank_htu_req_queue #(.DEPTH(4), .INFL(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .xbar_htu_valid_i(xbar_htu_valid_i), .xbar_htu_ready_o(xbar_htu_ready_o),
    .xbar_htu_ch_id_i(xbar_htu_ch_id_i), .xbar_htu_opcode_i(xbar_htu_opcode_i),
    .xbar_htu_addr_i(xbar_htu_addr_i), .xbar_htu_wbuffer_id_i(xbar_htu_wbuffer_id_i),
    .htu_pipe_valid_o(htu_pipe_valid_o), .htu_pipe_ready_i(htu_pipe_ready_i),
    .htu_pipe_ch_id_o(htu_pipe_ch_id_o), .htu_pipe_opcode_o(htu_pipe_opcode_o),
    .htu_pipe_addr_o(htu_pipe_addr_o), .htu_pipe_wbuffer_id_o(htu_pipe_wbuffer_id_o),
    .htu_pipe_done_i(htu_pipe_done_i), .queue_cnt_o(queue_cnt_o)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic enq(input logic [27:0] a);
    xbar_htu_valid_i = 1'b1;
    xbar_htu_addr_i = a;
    xbar_htu_ch_id_i = 2'($urandom_range(2));
    xbar_htu_opcode_i = 2'($urandom);
    xbar_htu_wbuffer_id_i = 8'($urandom);
    if (xbar_htu_ready_o) sb.push_back({xbar_htu_ch_id_i, xbar_htu_opcode_i, a, xbar_htu_wbuffer_id_i});
    cyc();
    xbar_htu_valid_i = 1'b0;
  endtask
  task automatic drain(input string tag);
    htu_pipe_ready_i = 1'b1;
    htu_pipe_done_i = 1'b1;
    for (int i = 0; i < 30 && queue_cnt_o != 0; i++) cyc();
    repeat (3) cyc();
    htu_pipe_ready_i = 1'b0;
    htu_pipe_done_i = 1'b0;
    chk({tag, "_drain_cnt"}, queue_cnt_o, 0);
    chk({tag, "_drain_vld"}, htu_pipe_valid_o, 0);
  endtask
  always @(negedge clk) begin
    if (!rst_i && htu_pipe_valid_o && htu_pipe_ready_i) begin
      if (sb.size() == 0) chk("issue_unexpected", 1, 0);
      else chk("issue_payload", {htu_pipe_ch_id_o, htu_pipe_opcode_o, htu_pipe_addr_o, htu_pipe_wbuffer_id_o}, sb.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) cyc();
    rst_i = 1'b0;
    chk("rst_ready", xbar_htu_ready_o, 1);
    chk("rst_valid", htu_pipe_valid_o, 0);
    chk("rst_cnt", queue_cnt_o, 0);
    // Ordering with immediate completion
    htu_pipe_ready_i = 1'b1;
    htu_pipe_done_i = 1'b1;
    enq(28'h100);
    chk("ord_first_vld", htu_pipe_valid_o, 1);
    chk("ord_first_addr", htu_pipe_addr_o, 28'h100);
    enq(28'h200);
    enq(28'h300);
    drain("ord");
    // Full queue
    for (int i = 0; i < 5; i++) begin
      chk("full_ready", xbar_htu_ready_o, i < 4);
      enq(28'h400 + 28'(i * 16));
    end
    chk("full_cnt", queue_cnt_o, 4);
    chk("full_ready_after", xbar_htu_ready_o, 0);
    htu_pipe_ready_i = 1'b1;
    chk("full_pop_vld", htu_pipe_valid_o, 1);
    chk("full_pop_ready", xbar_htu_ready_o, 0);
    cyc();
    htu_pipe_ready_i = 1'b0;
    chk("full_freed_ready", xbar_htu_ready_o, 1);
    chk("full_freed_cnt", queue_cnt_o, 3);
    drain("full");
    // Address hazard
    htu_pipe_ready_i = 1'b1;
    enq(28'h100);
    chk("haz_first_vld", htu_pipe_valid_o, 1);
    enq(28'h100);
    chk("haz_blocked", htu_pipe_valid_o, 0);
    chk("haz_cnt", queue_cnt_o, 1);
    cyc();
    chk("haz_still_blocked", htu_pipe_valid_o, 0);
    htu_pipe_done_i = 1'b1;
    chk("haz_done_cycle", htu_pipe_valid_o, 0);
    cyc();
    htu_pipe_done_i = 1'b0;
    chk("haz_released", htu_pipe_valid_o, 1);
    drain("haz");
    // Tracker full
    htu_pipe_ready_i = 1'b1;
    enq(28'h100);
    enq(28'h200);
    enq(28'h300);
    chk("trk_full_blk", htu_pipe_valid_o, 0);
    cyc();
    chk("trk_full_blk2", htu_pipe_valid_o, 0);
    htu_pipe_done_i = 1'b1;
    chk("trk_done_cycle", htu_pipe_valid_o, 0);
    cyc();
    htu_pipe_done_i = 1'b0;
    chk("trk_released", htu_pipe_valid_o, 1);
    chk("trk_rel_addr", htu_pipe_addr_o, 28'h300);
    drain("trk");
    // Enqueue, issue and done together
    htu_pipe_ready_i = 1'b1;
    enq(28'h500);
    enq(28'h600);
    htu_pipe_ready_i = 1'b0;
    enq(28'h700);
    htu_pipe_ready_i = 1'b1;
    htu_pipe_done_i = 1'b1;
    chk("sim_cnt_pre", queue_cnt_o, 2);
    chk("sim_vld_pre", htu_pipe_valid_o, 1);
    enq(28'h800);
    htu_pipe_ready_i = 1'b0;
    htu_pipe_done_i = 1'b0;
    chk("sim_cnt_post", queue_cnt_o, 2);
    chk("sim_trk_one", htu_pipe_valid_o, 1);
    htu_pipe_ready_i = 1'b1;
    cyc();
    htu_pipe_ready_i = 1'b0;
    chk("sim_trk_full", htu_pipe_valid_o, 0);
    drain("sim");
    // Reset mid-operation
    htu_pipe_ready_i = 1'b1;
    enq(28'h900);
    enq(28'ha00);
    enq(28'hb00);
    htu_pipe_ready_i = 1'b0;
    enq(28'hc00);
    enq(28'hd00);
    chk("rst2_cnt_pre", queue_cnt_o, 3);
    rst_i = 1'b1;
    sb.delete();
    cyc();
    rst_i = 1'b0;
    chk("rst2_cnt", queue_cnt_o, 0);
    chk("rst2_ready", xbar_htu_ready_o, 1);
    chk("rst2_valid", htu_pipe_valid_o, 0);
    htu_pipe_done_i = 1'b1;
    htu_pipe_ready_i = 1'b1;
    enq(28'h900);
    htu_pipe_done_i = 1'b0;
    chk("rst2_new_vld", htu_pipe_valid_o, 1);
    chk("rst2_new_addr", htu_pipe_addr_o, 28'h900);
    drain("rst2");
    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
